// File: rtl/symenc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : symenc_pkg
// Description : Shared types and defaults for the symbol-encoder UART path.
// Revision    : 1.0 - initial release
// ============================================================================
package symenc_pkg;

    // Serialiser frame phases: idle line, start bit, 8 data bits, stop bit
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DEFAULT_CLOCK_HZ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115200;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with extra-MSB pointers for full/empty
//               detection. Writes while full and reads while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [WIDTH-1:0]             i_wr_data,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_rd_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W:0] r_wr_ptr;
    logic [c_ADDR_W:0] r_rd_ptr;
    logic              w_full;
    logic              w_empty;
    logic              w_do_wr;
    logic              w_do_rd;

    // Same slot with differing wrap bits means the writer is a full lap ahead
    assign w_full  = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                     (r_wr_ptr[c_ADDR_W-1:0] == r_rd_ptr[c_ADDR_W-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_do_wr = i_wr_en && !w_full;
    assign w_do_rd = i_rd_en && !w_empty;

    assign o_rd_data = r_mem[r_rd_ptr[c_ADDR_W-1:0]];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_wr_ptr - r_rd_ptr;

    // Storage array; contents need no reset because the pointers gate all reads
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr[c_ADDR_W-1:0]] <= i_wr_data;
        end
    end

    // Pointer update; reset discards all queued entries
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Buffered 8N1 UART transmitter. Bytes enter a FIFO over a
//               valid/ready handshake and leave back-to-back at a fixed baud.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import symenc_pkg::*;
#(
    parameter int CLOCK_HZ   = DEFAULT_CLOCK_HZ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [7:0]                        in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              tx,
    output logic                              busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int c_CLKS_PER_BIT = CLOCK_HZ / BAUD;
    localparam int c_BAUD_W       = (c_CLKS_PER_BIT < 2) ? 1 : $clog2(c_CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_CLKS_PER_BIT - 1);

    if (c_CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLOCK_HZ / BAUD must be at least 2");
    end

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [7:0]          w_fifo_rd_data;
    logic                w_push;
    logic                w_pop;
    logic                w_baud_wrap;

    uart_state_t         r_state;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic                r_tx;

    // Ready depends only on registered FIFO state, so a same-cycle pop never frees a slot early
    assign in_ready    = !w_fifo_full;
    assign w_push      = in_valid && !w_fifo_full;
    assign w_baud_wrap = (r_baud_cnt == c_BAUD_LAST);
    // Pop from idle, or at the last stop-bit cycle to chain the next frame with no gap
    assign w_pop       = !w_fifo_empty &&
                         ((r_state == IDLE) || ((r_state == STOP) && w_baud_wrap));

    assign tx   = r_tx;
    assign busy = (r_state != IDLE) || !w_fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clock),
        .rst_n     (reset_n),
        .i_wr_en   (w_push),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (fifo_count)
    );

    // Serialiser FSM with baud counter; tx is registered and trails the state by one cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                IDLE:    r_tx <= 1'b1;
                START:   r_tx <= 1'b0;
                DATA:    r_tx <= r_shift[0];
                STOP:    r_tx <= 1'b1;
                default: r_tx <= 1'b1;
            endcase

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_shift    <= w_fifo_rd_data;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        r_shift    <= r_shift >> 1;
                        r_bit_idx  <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_wrap) begin
                        r_baud_cnt <= '0;
                        if (w_pop) begin
                            r_shift   <= w_fifo_rd_data;
                            r_bit_idx <= '0;
                            r_state   <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo using a frame-level
//               reference model, a serial-line monitor and literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int CLOCK_HZ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLOCK_HZ / BAUD;
    localparam int FRAME    = 10 * CPB;
    localparam int CW       = $clog2(DEPTH + 1);

    logic          clock    = 1'b0;
    logic          reset_n  = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    uart_tx_fifo #(
        .CLOCK_HZ   (CLOCK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (frame position + byte queue) ----------------
    logic [7:0] mq[$];
    logic [7:0] sent[$];
    logic [7:0] rx_q[$];
    int         pos       = -1;
    logic [7:0] cur       = 8'h00;
    logic       exp_tx    = 1'b1;
    logic       exp_busy  = 1'b0;
    logic       exp_ready = 1'b1;
    int         exp_cnt   = 0;

    function automatic logic line_bit(input int p, input logic [7:0] b);
        int k;
        k = p / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if (pos >= 0 && sent.size() > 0) sent.delete(sent.size() - 1);
            mq.delete();
            pos    = -1;
            exp_tx = 1'b1;
        end else begin
            int  sz;
            bit  acc;
            bit  do_pop;
            sz     = mq.size();
            acc    = in_valid && (sz < DEPTH);
            do_pop = (sz > 0) && ((pos < 0) || (pos == FRAME - 1));
            exp_tx = (pos < 0) ? 1'b1 : line_bit(pos, cur);
            if (do_pop) begin
                cur = mq.pop_front();
                sent.push_back(cur);
                pos = 0;
            end else if (pos == FRAME - 1) begin
                pos = -1;
            end else if (pos >= 0) begin
                pos++;
            end
            if (acc) mq.push_back(in_data);
        end
        exp_cnt   = mq.size();
        exp_ready = (mq.size() < DEPTH);
        exp_busy  = (pos >= 0) || (mq.size() > 0);
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        chk("tx", tx, exp_tx);
        chk("busy", busy, exp_busy);
        chk("fifo_count", fifo_count, exp_cnt);
        chk("in_ready", in_ready, exp_ready);
    end

    // ---------------- serial line monitor ----------------
    int         mon_cnt = -1;
    logic [7:0] mon_sh  = 8'h00;
    always @(negedge clock) begin
        if (!reset_n) begin
            mon_cnt = -1;
        end else if (mon_cnt < 0) begin
            if (tx === 1'b0) mon_cnt = 0;
        end else begin
            mon_cnt++;
            if ((mon_cnt % CPB) == CPB / 2) begin
                int k;
                k = mon_cnt / CPB;
                if (k >= 1 && k <= 8) mon_sh[k-1] = tx;
                if (k == 9) begin
                    chk("stop_bit", tx, 1);
                    rx_q.push_back(mon_sh);
                    mon_cnt = -1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic [7:0] b, output int acc);
        int guard;
        guard = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 1000) begin
            chk("push_timeout", 0, 1);
            in_valid = 1'b0;
            acc = -1;
        end else begin
            acc = cyc + 1;
            @(posedge clock);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_until(input int n);
        do begin
            @(negedge clock);
            in_valid = 1'b0;
        end while (cyc < n);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clock);
        in_valid = 1'b0;
        while (busy !== 1'b0 && g < 3000) begin
            @(negedge clock);
            g++;
        end
        chk("drain_busy", busy, 0);
        idle(3);
    endtask

    task automatic compare_stream();
        chk("rx_count", rx_q.size(), sent.size());
        for (int i = 0; i < rx_q.size() && i < sent.size(); i++) begin
            chk("rx_byte", rx_q[i], sent[i]);
        end
        rx_q.delete();
        sent.delete();
    endtask

    logic       cap_tx   [0:101];
    logic       cap_busy [0:101];
    logic [2:0] cap_cnt  [0:101];

    task automatic capture(input logic [7:0] b, output int acc);
        push(b, acc);
        for (int k = 0; k <= 101; k++) begin
            @(negedge clock);
            if (k == 0) in_valid = 1'b0;
            cap_tx[k]   = tx;
            cap_busy[k] = busy;
            cap_cnt[k]  = fifo_count;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ea, eb, ed, e1, e6, t;
        logic [9:0] bits;
        logic [7:0] rb;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_tx", tx, 1);
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        reset_n = 1'b1;
        idle(2);

        // Single byte 0x55
        capture(8'h55, ea);
        bits = 10'b1010101010;
        chk("t1_cnt_after_push", cap_cnt[0], 1);
        chk("t1_tx_e1", cap_tx[1], 1);
        chk("t1_tx_fall_e2", cap_tx[2], 0);
        for (int b = 0; b < 10; b++) chk("t1_bit", cap_tx[2 + 10 * b + 5], bits[b]);
        chk("t1_busy_e100", cap_busy[100], 1);
        chk("t1_busy_e101", cap_busy[101], 0);
        chk("t1_cnt_end", cap_cnt[101], 0);
        wait_idle();
        rb = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        chk("t1_rx", rb, 8'h55);
        compare_stream();

        // LSB-first ordering with 0xA5
        capture(8'hA5, ea);
        bits = 10'b1101001010;
        for (int b = 0; b < 10; b++) chk("t2_bit", cap_tx[2 + 10 * b + 5], bits[b]);
        wait_idle();
        compare_stream();

        // Back-to-back frames and full FIFO
        push(8'h01, e1);
        for (int v = 2; v <= 5; v++) push(8'(v), t);
        @(negedge clock);
        in_valid = 1'b0;
        chk("t3_count_full", fifo_count, 4);
        chk("t3_ready_low", in_ready, 0);
        push(8'h06, e6);
        chk("t3_stall_len", e6 - e1, 102);
        wait_idle();
        chk("t3_rx_count", rx_q.size(), 6);
        for (int i = 0; i < rx_q.size() && i < 6; i++) chk("t3_rx_order", rx_q[i], i + 1);
        compare_stream();

        // Simultaneous push and pop at the STOP->START edge
        push(8'hA1, ea);
        push(8'hB2, eb);
        push(8'hC3, t);
        wait_until(ea + 99);
        push(8'hD4, ed);
        chk("t4_acc_edge", ed, ea + 101);
        @(negedge clock);
        in_valid = 1'b0;
        chk("t4_count_hold", fifo_count, 2);
        wait_idle();
        chk("t4_rx_count", rx_q.size(), 4);
        if (rx_q.size() == 4) begin
            chk("t4_rx0", rx_q[0], 8'hA1);
            chk("t4_rx1", rx_q[1], 8'hB2);
            chk("t4_rx2", rx_q[2], 8'hC3);
            chk("t4_rx3", rx_q[3], 8'hD4);
        end
        compare_stream();

        // Reset during data bit 3
        push(8'h96, ea);
        push(8'h11, t);
        wait_until(ea + 44);
        chk("t5_pre_reset_tx", tx, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_count", fifo_count, 0);
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_busy", busy, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        idle(2);
        push(8'h3C, t);
        wait_idle();
        chk("t5_rx_count", rx_q.size(), 1);
        rb = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
        chk("t5_rx", rb, 8'h3C);
        compare_stream();

        // Wrap-around stream with random gaps
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 3));
            push(8'($urandom_range(0, 255)), t);
        end
        wait_idle();
        chk("t6_rx_count", rx_q.size(), 12);
        compare_stream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
